// File: rtl/branch_predictor_if.sv
// Fetch/resolve bus of the branch predictor.
// master: fetch + execute side (drives PCs and resolutions), slave: the predictor.
interface branch_predictor_if;
  // Fetch-side lookup
  logic [63:0] f_pc;
  logic        pred_jump;
  logic [63:0] pred_pc;
  // Execute-side resolution
  logic        u_valid;
  logic [63:0] u_pc;
  logic        u_is_branch;
  logic        u_is_jump;
  logic        u_is_call;
  logic        u_is_ret;
  logic        u_taken;
  logic [63:0] u_target;
  logic        u_pd_fail;
  // Statistics
  logic [31:0] mispred_cnt;

  modport master (
    output f_pc, u_valid, u_pc, u_is_branch, u_is_jump, u_is_call, u_is_ret,
           u_taken, u_target, u_pd_fail,
    input  pred_jump, pred_pc, mispred_cnt
  );

  modport slave (
    input  f_pc, u_valid, u_pc, u_is_branch, u_is_jump, u_is_call, u_is_ret,
           u_taken, u_target, u_pd_fail,
    output pred_jump, pred_pc, mispred_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with a 2-bit saturating
// counter per entry, trained by execute's resolution. Lookup is combinational
// and sees pre-update contents (no write-to-read bypass).
// Optional feature: define BPU_RAS_EN to add a non-speculative return address
// stack that supplies the target for hits on return entries.
module branch_predictor #(
  parameter int unsigned BTB_ENTRIES = 64,
  parameter int unsigned TAG_W       = 12,
  parameter int unsigned RAS_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              reset,
  branch_predictor_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);

  typedef enum logic [1:0] {
    KIND_BRANCH = 2'd0,
    KIND_JUMP   = 2'd1,
    KIND_RET    = 2'd2
  } kind_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [63:0]      target;
    logic [1:0]       ctr;
    kind_e            kind;
  } btb_entry_t;

  localparam btb_entry_t ENTRY_RESET = '{
    valid:  1'b0,
    tag:    '0,
    target: '0,
    ctr:    2'b01,
    kind:   KIND_BRANCH
  };

  btb_entry_t btb_q [BTB_ENTRIES];

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  btb_entry_t       f_entry;
  logic             f_hit;
  logic             pred_jump;
  logic [63:0]      pred_pc;

  // Return-stack view used by the lookup; tied off when the stack is absent.
  logic             ras_valid;
  logic [63:0]      ras_top;

  assign f_idx   = bus.f_pc[IDX_W+1:2];
  assign f_tag   = bus.f_pc[IDX_W+2 +: TAG_W];
  assign f_entry = btb_q[f_idx];
  assign f_hit   = f_entry.valid && (f_entry.tag == f_tag);

  // Only the counter MSB carries the direction.
  logic unused_lookup;
  assign unused_lookup = f_entry.ctr[0];

  // Prediction: jumps/returns always taken on hit, branches follow counter MSB.
  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    pred_jump = 1'b0;
    pred_pc   = bus.f_pc + 64'd4;
    if (f_hit && ((f_entry.kind != KIND_BRANCH) || f_entry.ctr[1])) begin
      pred_jump = 1'b1;
      pred_pc   = f_entry.target;
      if ((f_entry.kind == KIND_RET) && ras_valid) begin
        pred_pc = ras_top;
      end
    end
  end

  assign bus.pred_jump = pred_jump;
  assign bus.pred_pc   = pred_pc;

  // ---------------------------------------------------------------------------
  // Training
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  btb_entry_t       u_entry;
  logic             u_hit;
  kind_e            u_kind;
  logic             btb_we;
  btb_entry_t       entry_d;

  assign u_idx   = bus.u_pc[IDX_W+1:2];
  assign u_tag   = bus.u_pc[IDX_W+2 +: TAG_W];
  assign u_entry = btb_q[u_idx];
  assign u_hit   = u_entry.valid && (u_entry.tag == u_tag);

  // Classify the resolved instruction; return wins over plain jump.
  always_comb begin
    u_kind = KIND_BRANCH;
    if (bus.u_is_ret) begin
      u_kind = KIND_RET;
    end else if (bus.u_is_jump) begin
      u_kind = KIND_JUMP;
    end
  end

  // Next contents of the indexed entry: train on hit, allocate on taken miss.
  always_comb begin
    btb_we  = 1'b0;
    entry_d = u_entry;
    if (bus.u_valid && (bus.u_is_branch || bus.u_is_jump)) begin
      if (u_hit) begin
        btb_we = 1'b1;
        if (u_kind == KIND_BRANCH) begin
          if (bus.u_taken) begin
            if (u_entry.ctr != 2'b11) entry_d.ctr = u_entry.ctr + 2'd1;
            entry_d.target = bus.u_target;
          end else if (u_entry.ctr != 2'b00) begin
            entry_d.ctr = u_entry.ctr - 2'd1;
          end
        end else begin
          entry_d.target = bus.u_target;
        end
      end else if (bus.u_taken) begin
        btb_we         = 1'b1;
        entry_d.valid  = 1'b1;
        entry_d.tag    = u_tag;
        entry_d.target = bus.u_target;
        entry_d.ctr    = 2'b10;
        entry_d.kind   = u_kind;
      end
    end
  end

  // BTB storage: whole table cleared asynchronously, one entry written per cycle.
  // NOTE: the table is reset entry by entry because valid=0 and ctr=01 are visible
  // state right after reset; storage that a valid/count flag already gates needs no reset.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_q[i] <= ENTRY_RESET;
      end
    end else if (btb_we) begin
      btb_q[u_idx] <= entry_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Misprediction counter
  // ---------------------------------------------------------------------------
  logic [31:0] mispred_q;
  logic [31:0] mispred_d;

  // Count resolved mispredictions, sticking at all-ones.
  always_comb begin
    mispred_d = mispred_q;
    if (bus.u_valid && bus.u_pd_fail && (mispred_q != 32'hFFFF_FFFF)) begin
      mispred_d = mispred_q + 32'd1;
    end
  end

  // Misprediction counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispred_q <= '0;
    end else begin
      mispred_q <= mispred_d;
    end
  end

  assign bus.mispred_cnt = mispred_q;

  // ---------------------------------------------------------------------------
  // Return address stack
  // ---------------------------------------------------------------------------
`ifdef BPU_RAS_EN
  localparam int unsigned RAS_PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned RAS_CNT_W = RAS_PTR_W + 1;

  logic [63:0]          ras_q [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] ras_sp_q;      // next free slot; top is ras_sp_q-1
  logic [RAS_PTR_W-1:0] ras_sp_d;
  logic [RAS_CNT_W-1:0] ras_cnt_q;
  logic [RAS_CNT_W-1:0] ras_cnt_d;
  logic [RAS_PTR_W-1:0] ras_top_idx;
  logic                 ras_push;
  logic                 ras_pop;
  logic                 ras_we;
  logic [RAS_PTR_W-1:0] ras_wr_idx;
  logic [63:0]          ras_wr_data;

  assign ras_top_idx = ras_sp_q - 1'b1;
  assign ras_valid   = (ras_cnt_q != '0);
  assign ras_top     = ras_q[ras_top_idx];
  assign ras_push    = bus.u_valid && bus.u_is_call;
  assign ras_pop     = bus.u_valid && bus.u_is_ret && ras_valid;
  assign ras_wr_data = bus.u_pc + 64'd4;

  // Stack pointer/count update; a full stack wraps and overwrites its oldest slot.
  always_comb begin
    ras_sp_d   = ras_sp_q;
    ras_cnt_d  = ras_cnt_q;
    ras_we     = 1'b0;
    ras_wr_idx = ras_sp_q;
    if (ras_push && ras_pop) begin
      // Pop then push collapses to replacing the top in place.
      ras_we     = 1'b1;
      ras_wr_idx = ras_top_idx;
    end else if (ras_pop) begin
      ras_sp_d  = ras_top_idx;
      ras_cnt_d = ras_cnt_q - 1'b1;
    end else if (ras_push) begin
      ras_we   = 1'b1;
      ras_sp_d = ras_sp_q + 1'b1;
      if (ras_cnt_q != RAS_CNT_W'(RAS_DEPTH)) begin
        ras_cnt_d = ras_cnt_q + 1'b1;
      end
    end
  end

  // Stack pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ras_sp_q  <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_sp_q  <= ras_sp_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  // Stack storage; contents are only read while ras_cnt_q is non-zero.
  always_ff @(posedge clk) begin
    if (ras_we) begin
      ras_q[ras_wr_idx] <= ras_wr_data;
    end
  end
`else
  assign ras_valid = 1'b0;
  assign ras_top   = '0;

  // Without the stack, calls train only as jumps and the low/high PC bits go unused.
  logic unused_no_ras;
  assign unused_no_ras = ^{bus.u_is_call, bus.u_pc[1:0], bus.u_pc[63:IDX_W+2+TAG_W]};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios with constant
// expectations plus randomized resolutions compared against a table/queue model.
module tb_branch_predictor;

  localparam int BTB_ENTRIES = 64;
  localparam int TAG_W       = 12;
  localparam int RAS_DEPTH   = 8;
  localparam int IDX_W       = $clog2(BTB_ENTRIES);
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  branch_predictor_if bus ();

  branch_predictor #(
    .BTB_ENTRIES(BTB_ENTRIES),
    .TAG_W      (TAG_W),
    .RAS_DEPTH  (RAS_DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    bit              valid;
    longint unsigned tag;
    logic [63:0]     target;
    int              ctr;
    int              kind;   // 0 branch, 1 jump, 2 ret
  } m_entry_t;

  m_entry_t        m_btb [BTB_ENTRIES];
  logic [63:0]     m_ras [$];
  longint unsigned m_cnt;

  function automatic int m_idx(input logic [63:0] pc);
    return int'((pc >> 2) % BTB_ENTRIES);
  endfunction

  function automatic longint unsigned m_tag(input logic [63:0] pc);
    return (pc >> (IDX_W + 2)) % (64'd1 << TAG_W);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      m_btb[i].valid  = 0;
      m_btb[i].tag    = 0;
      m_btb[i].target = '0;
      m_btb[i].ctr    = 1;
      m_btb[i].kind   = 0;
    end
    m_ras.delete();
    m_cnt = 0;
  endfunction

  function automatic void m_predict(input logic [63:0] pc, output bit j, output logic [63:0] p);
    int i;
    i = m_idx(pc);
    j = 0;
    p = pc + 64'd4;
    if (m_btb[i].valid && m_btb[i].tag == m_tag(pc) && (m_btb[i].kind != 0 || m_btb[i].ctr >= 2)) begin
      j = 1;
      p = m_btb[i].target;
`ifdef BPU_RAS_EN
      if (m_btb[i].kind == 2 && m_ras.size() > 0) p = m_ras[$];
`endif
    end
  endfunction

  function automatic void m_update(input bit vld, input logic [63:0] pc, input bit br, jmp, call, ret,
                                   input bit taken, input logic [63:0] tgt, input bit pdf);
    int i;
    int kind;
    longint unsigned t;
    if (!vld) return;
    if (pdf && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    kind = ret ? 2 : (jmp ? 1 : 0);
    i = m_idx(pc);
    t = m_tag(pc);
    if (br || jmp) begin
      if (m_btb[i].valid && m_btb[i].tag == t) begin
        if (kind == 0) begin
          if (taken) begin
            m_btb[i].ctr    = (m_btb[i].ctr < 3) ? m_btb[i].ctr + 1 : 3;
            m_btb[i].target = tgt;
          end else begin
            m_btb[i].ctr = (m_btb[i].ctr > 0) ? m_btb[i].ctr - 1 : 0;
          end
        end else begin
          m_btb[i].target = tgt;
        end
      end else if (taken) begin
        m_btb[i].valid  = 1;
        m_btb[i].tag    = t;
        m_btb[i].target = tgt;
        m_btb[i].ctr    = 2;
        m_btb[i].kind   = kind;
      end
    end
`ifdef BPU_RAS_EN
    if (ret && m_ras.size() > 0) void'(m_ras.pop_back());
    if (call) begin
      m_ras.push_back(pc + 64'd4);
      if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
    end
`else
    if (call) return;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    bus.u_valid     = 1'b0;
    bus.u_pc        = '0;
    bus.u_is_branch = 1'b0;
    bus.u_is_jump   = 1'b0;
    bus.u_is_call   = 1'b0;
    bus.u_is_ret    = 1'b0;
    bus.u_taken     = 1'b0;
    bus.u_target    = '0;
    bus.u_pd_fail   = 1'b0;
  endtask

  // One resolution cycle; DUT and model update on the same edge.
  task automatic resolve(input logic [63:0] pc, input bit br, jmp, call, ret, taken,
                         input logic [63:0] tgt, input bit pdf = 1'b0, input bit vld = 1'b1);
    bus.u_valid     = vld;
    bus.u_pc        = pc;
    bus.u_is_branch = br;
    bus.u_is_jump   = jmp;
    bus.u_is_call   = call;
    bus.u_is_ret    = ret;
    bus.u_taken     = taken;
    bus.u_target    = tgt;
    bus.u_pd_fail   = pdf;
    @(posedge clk);
    m_update(vld, pc, br, jmp, call, ret, taken, tgt, pdf);
    #1;
    idle_inputs();
  endtask

  task automatic expect_pred(input string tag, input logic [63:0] pc, input bit ej, input logic [63:0] ep);
    bus.f_pc = pc;
    #1;
    check({tag, "_jump"}, bus.pred_jump, ej);
    check({tag, "_pc"}, bus.pred_pc, ep);
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_reset();
  endtask

  // Random pool: word offsets from BASE; 68/73/97 alias 4/9/33 in a 64-entry table.
  int pool_k    [10] = '{4, 68, 5, 9, 73, 20, 33, 97, 40, 41};
  int pool_kind [10] = '{0, 0, 1, 2, 3, 0, 0, 2, 4, 0};   // 3 = call, 4 = non-control

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    bus.f_pc = 64'h8000_0000;
    reset    = 1'b1;
    m_reset();
    #12;
    check("reset_cnt_during", bus.mispred_cnt, 32'd0);
    check("reset_jump_during", bus.pred_jump, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // 1. Reset state
    expect_pred("t1", 64'h8000_0000, 1'b0, 64'h8000_0004);
    check("t1_cnt", bus.mispred_cnt, 32'd0);
    expect_pred("wrap", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0);

    // 2. Allocate on taken branch, then two not-taken drop below threshold
    resolve(64'h8000_0010, 1, 0, 0, 0, 1, 64'h8000_0100);
    expect_pred("t2_alloc", 64'h8000_0010, 1'b1, 64'h8000_0100);
    resolve(64'h8000_0010, 1, 0, 0, 0, 0, 64'h8000_0014);
    resolve(64'h8000_0010, 1, 0, 0, 0, 0, 64'h8000_0014);
    expect_pred("t2_nt", 64'h8000_0010, 1'b0, 64'h8000_0014);

    // 3. Saturation at strongly taken
    for (int i = 0; i < 5; i++) resolve(64'h8000_0010, 1, 0, 0, 0, 1, 64'h8000_0100);
    resolve(64'h8000_0010, 1, 0, 0, 0, 0, 64'h8000_0014);
    expect_pred("t3_one_nt", 64'h8000_0010, 1'b1, 64'h8000_0100);
    resolve(64'h8000_0010, 1, 0, 0, 0, 0, 64'h8000_0014);
    expect_pred("t3_two_nt", 64'h8000_0010, 1'b0, 64'h8000_0014);

    // 4. Aliasing eviction
    resolve(64'h8000_0010 + 4 * BTB_ENTRIES, 1, 0, 0, 0, 1, 64'h8000_0200);
    expect_pred("t4_evicted", 64'h8000_0010, 1'b0, 64'h8000_0014);
    expect_pred("t4_new", 64'h8000_0010 + 4 * BTB_ENTRIES, 1'b1, 64'h8000_0200);

    // Return entry with empty (or absent) stack predicts its BTB target
    resolve(64'h8000_0400, 0, 1, 0, 1, 1, 64'h8000_0ABC);
    expect_pred("ret_btb", 64'h8000_0400, 1'b1, 64'h8000_0ABC);

`ifdef BPU_RAS_EN
    // 5. Return address stack. The calls are presented without the jump flag
    //    so their BTB slots (which alias the return at 0x400) stay untouched.
    apply_reset();
    resolve(64'h400, 0, 1, 0, 1, 1, 64'h999);
    expect_pred("ras_empty0", 64'h400, 1'b1, 64'h999);
    resolve(64'h100, 0, 0, 1, 0, 1, 64'h0);
    resolve(64'h200, 0, 0, 1, 0, 1, 64'h0);
    resolve(64'h300, 0, 0, 1, 0, 1, 64'h0);
    expect_pred("ras_top3", 64'h400, 1'b1, 64'h304);
    resolve(64'h400, 0, 1, 0, 1, 1, 64'h999);
    expect_pred("ras_top2", 64'h400, 1'b1, 64'h204);
    resolve(64'h400, 0, 1, 0, 1, 1, 64'h999);
    expect_pred("ras_top1", 64'h400, 1'b1, 64'h104);
    resolve(64'h400, 0, 1, 0, 1, 1, 64'h999);
    expect_pred("ras_empty1", 64'h400, 1'b1, 64'h999);
    for (int i = 0; i <= RAS_DEPTH; i++) resolve(64'h1000 + 64'(16 * i), 0, 0, 1, 0, 1, 64'h0);
    for (int i = RAS_DEPTH; i >= 1; i--) begin
      expect_pred("ras_ovf", 64'h400, 1'b1, 64'h1000 + 64'(16 * i) + 64'd4);
      resolve(64'h400, 0, 1, 0, 1, 1, 64'h999);
    end
    expect_pred("ras_oldest_lost", 64'h400, 1'b1, 64'h999);
    resolve(64'h400, 0, 1, 0, 1, 1, 64'h999);
    expect_pred("ras_underflow", 64'h400, 1'b1, 64'h999);
    resolve(64'h2000, 0, 0, 1, 0, 1, 64'h0);
    expect_pred("ras_push", 64'h400, 1'b1, 64'h2004);
    resolve(64'h3000, 0, 0, 1, 1, 1, 64'h0);
    expect_pred("ras_callret", 64'h400, 1'b1, 64'h3004);
    resolve(64'h400, 0, 1, 0, 1, 1, 64'h999);
    expect_pred("ras_callret_cnt", 64'h400, 1'b1, 64'h999);
`endif

    // Randomized resolutions; each lookup sees pre-update contents
    for (int n = 0; n < 800; n++) begin
      int          p;
      int          kind;
      bit          ej;
      logic [63:0] ep;
      logic [63:0] pc;
      logic [63:0] tgt;
      bit          vld, br, jmp, call, ret, taken, pdf;
      p     = $urandom_range(0, 9);
      kind  = pool_kind[p];
      pc    = BASE + 64'(4 * pool_k[p]);
      tgt   = {32'h0, $urandom} & ~64'h3;
      vld   = ($urandom_range(0, 3) != 0);
      br    = (kind == 0);
      jmp   = (kind == 1 || kind == 2 || kind == 3);
      call  = (kind == 3);
      ret   = (kind == 2);
      taken = (kind == 0) ? bit'($urandom_range(0, 1)) : (kind != 4);
      pdf   = bit'($urandom_range(0, 1));
      bus.u_valid     = vld;
      bus.u_pc        = pc;
      bus.u_is_branch = br;
      bus.u_is_jump   = jmp;
      bus.u_is_call   = call;
      bus.u_is_ret    = ret;
      bus.u_taken     = taken;
      bus.u_target    = tgt;
      bus.u_pd_fail   = pdf;
      if ($urandom_range(0, 4) == 0) bus.f_pc = {$urandom, $urandom};
      else bus.f_pc = BASE + 64'(4 * pool_k[$urandom_range(0, 9)]);
      #1;
      m_predict(bus.f_pc, ej, ep);
      check("rnd_jump", bus.pred_jump, ej);
      check("rnd_pc", bus.pred_pc, ep);
      @(posedge clk);
      m_update(vld, pc, br, jmp, call, ret, taken, tgt, pdf);
      #1;
      if (n % 50 == 49) check("rnd_cnt", bus.mispred_cnt, m_cnt);
    end
    idle_inputs();

    // 6. Misprediction counting, then asynchronous reset mid-update
    apply_reset();
    resolve(64'h8000_0050, 0, 0, 0, 0, 0, 64'h0, 1'b1, 1'b1);
    resolve(64'h8000_0050, 0, 0, 0, 0, 0, 64'h0, 1'b1, 1'b0);
    resolve(64'h8000_0050, 0, 0, 0, 0, 0, 64'h0, 1'b1, 1'b1);
    check("t6_cnt", bus.mispred_cnt, 32'd2);
    expect_pred("t6_no_train", 64'h8000_0050, 1'b0, 64'h8000_0054);
    resolve(64'h8000_0060, 1, 0, 0, 0, 1, 64'h8000_0600);
    expect_pred("t6_pre", 64'h8000_0060, 1'b1, 64'h8000_0600);
    bus.u_valid     = 1'b1;
    bus.u_pc        = 64'h8000_0060;
    bus.u_is_branch = 1'b1;
    bus.u_taken     = 1'b1;
    bus.u_target    = 64'h8000_0700;
    bus.u_pd_fail   = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    expect_pred("t6_async", 64'h8000_0060, 1'b0, 64'h8000_0064);
    check("t6_async_cnt", bus.mispred_cnt, 32'd0);
    @(posedge clk);
    #1;
    check("t6_held_cnt", bus.mispred_cnt, 32'd0);
    reset = 1'b0;
    idle_inputs();
    m_reset();
    @(posedge clk);
    #1;
    expect_pred("t6_after", 64'h8000_0060, 1'b0, 64'h8000_0064);
    check("t6_after_cnt", bus.mispred_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
